// File: rtl/writeback_arbiter.sv
// Purpose: single write-port arbiter (ALU over buffered LSU) plus pending-destination busy mask.
// Latency: ALU result -> rf_we one cycle later; LSU result -> earliest rf_we two cycles after acceptance.
// Backpressure: ALU never stalled; LSU held off via lsu_ready when the 2-entry result FIFO is full.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data  single-cycle ALU result, always accepted, strict priority
//   lsu_valid/lsu_ready        LSU result handshake; lsu_rd/lsu_data carried with it
//   issue_valid/issue_rd       long-latency issue, marks issue_rd busy
//   busy                       pending-destination mask (bit 0 always 0)
//   rf_we/rf_waddr/rf_wdata    registered register-file write port
//   lsu_count                  FIFO occupancy
module writeback_arbiter #(
    parameter  int LSU_DEPTH = 2,
    localparam int CNT_W     = $clog2(LSU_DEPTH + 1),
    localparam int PTR_W     = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [63:0]      alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [4:0]       lsu_rd,
    input  logic [63:0]      lsu_data,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    output logic [31:0]      busy,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [63:0]      rf_wdata,
    output logic [CNT_W-1:0] lsu_count
);

    logic [4:0]       fifo_rd   [LSU_DEPTH];
    logic [63:0]      fifo_data [LSU_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             push;
    logic             pop;
    logic             sel_valid;
    logic [4:0]       sel_rd;
    logic [63:0]      sel_data;
    logic [31:0]      busy_nxt;

    // Readiness looks only at current occupancy: a full FIFO refuses a push
    // even in a cycle where it also pops, keeping the ready path short.
    assign lsu_ready = !reset && (lsu_count < CNT_W'(LSU_DEPTH));
    assign push      = lsu_valid && lsu_ready;
    // Head is only eligible when the ALU is idle; a just-pushed entry is not
    // visible until the next cycle because count updates at the edge.
    assign pop       = !alu_valid && (lsu_count != '0);

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = alu_rd;
        sel_data  = alu_data;
        if (alu_valid) begin
            sel_valid = 1'b1;
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_rd[rd_ptr];
            sel_data  = fifo_data[rd_ptr];
        end
    end

    // Clear for the popped entry is applied first so a same-cycle issue to
    // the same register re-sets the bit (the new op is still outstanding).
    always_comb begin
        busy_nxt = busy;
        if (pop) begin
            busy_nxt[fifo_rd[rd_ptr]] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(LSU_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= 64'd0;
            busy      <= 32'd0;
            lsu_count <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            // rd=0 results are consumed but never reach the register file.
            rf_we    <= sel_valid && (sel_rd != 5'd0);
            rf_waddr <= sel_rd;
            rf_wdata <= sel_data;
            busy     <= busy_nxt;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   lsu_count <= lsu_count + CNT_W'(1);
                2'b01:   lsu_count <= lsu_count - CNT_W'(1);
                default: lsu_count <= lsu_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= lsu_rd;
            fifo_data[wr_ptr] <= lsu_data;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [1:0]  lsu_count;

    int checks = 0;
    int errors = 0;

    writeback_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .lsu_count   (lsu_count)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of buffered LSU results and a
    // per-register pending flag, updated by the rules of each cycle.
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    typedef struct {
        logic        we;
        logic        chk_ad;
        logic [4:0]  addr;
        logic [63:0] data;
        logic [31:0] busy;
        logic [1:0]  cnt;
    } exp_t;

    ent_t mq[$];
    bit   mbusy[32];
    exp_t expq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares the DUT's registered outputs after each edge against
    // the expectation the driver queued for that edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                check("rf_we", 64'(rf_we), 64'(e.we));
                if (e.chk_ad) begin
                    check("rf_waddr", 64'(rf_waddr), 64'(e.addr));
                    check("rf_wdata", rf_wdata, e.data);
                end
                check("busy", 64'(busy), 64'(e.busy));
                check("lsu_count", 64'(lsu_count), 64'(e.cnt));
            end
        end
    end

    task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [63:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                        input logic iv, input logic [4:0] ird);
        exp_t  e;
        ent_t  h;
        bit    src;
        bit    pushed;
        logic [4:0]  srd;
        logic [63:0] sdata;
        @(negedge clk);
        reset = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        issue_valid = iv; issue_rd = ird;
        #1;
        check("lsu_ready", 64'(lsu_ready), 64'(!r && mq.size() < 2));
        e = '{we: 1'b0, chk_ad: 1'b1, addr: 5'd0, data: 64'd0, busy: 32'd0, cnt: 2'd0};
        if (r) begin
            mq.delete();
            foreach (mbusy[i]) mbusy[i] = 1'b0;
        end else begin
            pushed = lv && (mq.size() < 2);
            src = 1'b0; srd = 5'd0; sdata = 64'd0;
            if (av) begin
                src = 1'b1; srd = ard; sdata = ad;
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                src = 1'b1; srd = h.rd; sdata = h.data;
                mbusy[h.rd] = 1'b0;
            end
            if (iv && ird != 0) mbusy[ird] = 1'b1;
            mbusy[0] = 1'b0;
            if (pushed) mq.push_back('{rd: lrd, data: ld});
            e.we     = src && (srd != 0);
            e.chk_ad = e.we;
            e.addr   = srd;
            e.data   = sdata;
            for (int i = 0; i < 32; i++) e.busy[i] = mbusy[i];
            e.cnt    = 2'(mq.size());
        end
        expq.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0; issue_valid = 0; issue_rd = 0;

        // Reset held two cycles with ALU traffic present, then released.
        step(1, 1, 5, 64'h1111, 1, 4, 64'h2222, 1, 6);
        step(1, 1, 5, 64'h1111, 1, 4, 64'h2222, 1, 6);
        idle();

        // ALU path, including rd=0 suppression.
        step(0, 1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 0);
        step(0, 1, 0, 64'h1234, 0, 0, 0, 0, 0);
        idle();

        // Priority and backpressure: LSU results park behind continuous ALU.
        step(0, 1, 1, 64'h100, 0, 0, 0, 1, 7);
        step(0, 1, 2, 64'h200, 0, 0, 0, 1, 9);
        step(0, 1, 3, 64'h300, 1, 7, 64'h7777, 0, 0);
        step(0, 1, 4, 64'h400, 1, 9, 64'h9999, 0, 0);
        step(0, 1, 5, 64'h500, 1, 11, 64'hBBBB, 0, 0);
        step(0, 1, 6, 64'h600, 1, 11, 64'hBBBB, 0, 0);
        idle(); idle(); idle();

        // Steady push+pop at count=1 across pointer wrap.
        step(0, 0, 0, 0, 1, 10, 64'hA, 1, 10);
        step(0, 0, 0, 0, 1, 11, 64'hB, 0, 0);
        step(0, 0, 0, 0, 1, 12, 64'hC, 0, 0);
        step(0, 0, 0, 0, 1, 13, 64'hD, 0, 0);
        idle(); idle();

        // Busy race: re-issue rd=3 in the cycle its entry pops; rd=0 issue ignored.
        step(0, 0, 0, 0, 0, 0, 0, 1, 3);
        step(0, 0, 0, 0, 1, 3, 64'h33, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 3);
        idle(); idle();

        // Reset with two buffered entries discards them.
        step(0, 0, 0, 0, 0, 0, 0, 1, 20);
        step(0, 1, 1, 64'h1, 1, 20, 64'h2020, 1, 21);
        step(0, 1, 2, 64'h2, 1, 21, 64'h2121, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(); idle(); idle();

        // Randomised traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                 $urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)));
        end
        idle(); idle(); idle();

        for (int k = 0; k < 10 && expq.size() > 0; k++) @(posedge clk);
        #2;
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Single write-port arbiter and pending-register scoreboard sitting directly upstream of the 32 x 64-bit register file. Merges results from the single-cycle ALU pipe, which is never stalled, and the long-latency load/store unit, which uses a valid/ready handshake. LSU results are buffered in a 2-entry FIFO, and the arbiter drives the register file's registered write port (we/waddr/wdata). Keeps a 32-bit busy mask of destinations with long-latency results still outstanding; issue logic reads it for stall decisions.

## Interface
- LSU_DEPTH, 2, LSU result FIFO depth; fixed at 2, and count width is derived from it.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rd  in  5  ALU destination register.
- alu_data  in  64  ALU result.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  FIFO can accept; transfer when lsu_valid && lsu_ready at rising edge.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  64  LSU result.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_rd  in  5  its destination; marks busy.
- busy  out  32  pending-destination mask; bit 0 is always 0.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  5  register file write address (registered).
- rf_wdata  out  64  register file write data (registered).
- lsu_count  out  2  FIFO occupancy, 0..2.

## Operation
- Select, combinational each cycle:
  - If alu_valid: source = ALU.
  - Else if FIFO non-empty: source = FIFO head, and the head pops at the edge.
  - Else: no write.
- ALU has strict priority; the FIFO drains only in cycles with alu_valid=0. Sustained ALU traffic holds the FIFO, and lsu_ready drops when the FIFO is full. No starvation guard; the issue logic bounds this.
- Write-port register, at the edge:
  - rf_we <= (source valid) && (rd != 0).
  - rf_waddr/rf_wdata <= selected rd/data. Both are updated even when rd=0 or no source, but meaningful only when rf_we=1.
  - An rd=0 result is consumed (FIFO pops) but never written.
- FIFO:
  - Push on lsu_valid && lsu_ready.
  - Pop when selected.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - No bypass: a pushed entry is not selectable until the following cycle.
- lsu_ready = !reset && (lsu_count < 2). Derived from current occupancy only, so a full FIFO refuses a push even if it pops that cycle.
- Scoreboard:
  - issue_valid && issue_rd != 0 sets busy[issue_rd].
  - Popping a FIFO entry clears busy[entry rd].
  - Same register set and cleared in the same cycle: set wins.
  - issue_rd = 0 is ignored.
  - ALU writes never modify busy.
- Write-after-write ordering between ALU and LSU to the same rd is upstream's responsibility, enforced via busy. The arbiter writes in selection order.

## Timing
- Reset (reset=1 at an edge):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - busy=0, lsu_count=0, FIFO pointers 0.
  - lsu_ready=0 while reset is high.
  - Reset mid-operation discards buffered LSU results and pending busy bits.
- ALU latency: alu_valid sampled at edge N -> rf_we=1 during cycle N..N+1; the register file commits at edge N+1.
- LSU latency: accepted at edge N -> earliest rf_we during cycle N+1..N+2; busy bit clears at edge N+1, visible in the same cycle rf_we is asserted.
- Throughput: one register file write per cycle; the FIFO sustains one LSU result per cycle when the ALU is idle.
- Boundaries:
  - FIFO full + alu_valid: no pop, lsu_ready=0.
  - Empty FIFO + no ALU: rf_we=0.
  - Pointer wrap modulo 2.
  - Count never exceeds 2 or goes below 0.

## Test plan
- Reset: hold reset 2 cycles with alu_valid=1 -> rf_we=0, busy=0, lsu_ready=0; after release lsu_ready=1, lsu_count=0.
- ALU path: alu_valid, rd=5, data=0xDEAD_BEEF_0000_0001 at edge N -> rf_we=1, waddr=5, wdata matches during cycle after N. rd=0 -> rf_we=0.
- Priority/backpressure: issue rd=7 and rd=9, push LSU rd=7 then rd=9 while alu_valid=1 continuously:
  - lsu_count reaches 2 and lsu_ready=0.
  - busy[7], busy[9] stay 1.
  - After alu_valid drops: writes rd=7 then rd=9 on consecutive cycles, and busy clears in that order.
- Simultaneous push/pop at count=1, ALU idle: count stays 1; FIFO order preserved across pointer wrap (push 4 entries 0xA..0xD, written 0xA..0xD).
- Scoreboard race: issue_valid rd=3 in the same cycle an LSU entry for rd=3 pops -> busy[3]=1 afterwards. issue_rd=0 -> busy[0] stays 0.
- Mid-operation reset with 2 buffered entries -> no write of either entry after reset; busy=0, lsu_count=0.
